lcd1602_seq_ctrl: RTL
=====================

Name: lcd1602_seq_ctrl

Overview:
- Top-level sequencer for the HD44780-style 16x2 LCD path on the 50 MHz clock.
- Waits out the power-up delay, then issues the init command list through the command writer.
- Then refreshes both lines forever: a DDRAM address command plus 16 characters fetched from an external 32-byte character buffer, written through the data writer.
- Muxes the writers' bus outputs onto the single LCD pin set and guarantees only one writer is active at a time.

Parameters:
- T_PWR, 750_000, power-up wait in clk cycles (15 ms at 50 MHz).
- T_REFRESH, 2_500_000, idle gap in cycles between full-screen refreshes (50 ms).
- CNT_W, 22, width of the shared delay counter; must hold max(T_PWR, T_REFRESH).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- wr_cmd_en  out  1  one-cycle start pulse to the command writer.
- wr_cmd  out  8  command byte, valid in the wr_cmd_en cycle.
- wr_cmd_done  in  1  one-cycle completion pulse from the command writer.
- wr_data_en  out  1  one-cycle start pulse to the data writer.
- wr_data  out  8  character byte, valid in the wr_data_en cycle.
- wr_data_done  in  1  one-cycle completion pulse from the data writer.
- cmd_q/cmd_rs/cmd_en  in  8/1/1  command writer LCD bus outputs.
- data_q/data_rs/data_en  in  8/1/1  data writer LCD bus outputs.
- char_addr  out  5  buffer index: 0-15 is line 1, 16-31 is line 2.
- char_data  in  8  buffer byte; combinational read of char_addr, sampled in the same cycle.
- lcd_db  out  8  LCD data bus.
- lcd_rs  out  1  LCD register select.
- lcd_rw  out  1  tied to 0 (write only).
- lcd_en  out  1  LCD enable strobe.
- init_done  out  1  high once the init list completes; held until reset.

Behaviour:
- Reset (async assert, sync deassert use): state=PWR_WAIT, counter=0, all *_en=0, wr_cmd=0, wr_data=0, char_addr=0, init_done=0, bus select=CMD.
- FSM states:
  - PWR_WAIT: count to T_PWR-1, then go to INIT_ISSUE with idx=0.
  - INIT_ISSUE: pulse wr_cmd_en for exactly 1 cycle with wr_cmd=INIT[idx]; go to INIT_WAIT.
  - INIT_WAIT: on wr_cmd_done, idx++. If idx was 3, set init_done=1 and go to ADDR_ISSUE with line=0; otherwise go to INIT_ISSUE.
  - INIT list, in order: 0x38, 0x0C, 0x06, 0x01.
  - ADDR_ISSUE: wr_cmd_en pulse with wr_cmd = 0x80 for line 0, 0xC0 for line 1; go to ADDR_WAIT.
  - ADDR_WAIT: on wr_cmd_done, col=0 and go to DATA_ISSUE.
  - DATA_ISSUE: char_addr={line,col[3:0]}; wr_data=char_data registered in this cycle; wr_data_en pulses the same cycle; go to DATA_WAIT.
  - DATA_WAIT: on wr_data_done, col++. If col was 15: line 0 goes to ADDR_ISSUE with line=1; line 1 goes to REFRESH_WAIT. Otherwise go to DATA_ISSUE.
  - REFRESH_WAIT: count to T_REFRESH-1, then go to ADDR_ISSUE with line=0. The init list is never reissued.
- Exactly one request outstanding at a time. A new *_en never asserts before the done of the previous request.
- Done pulses arriving in a state not waiting for them are ignored; no state change.
- Bus mux: select=DATA from the DATA_ISSUE cycle until that request's done, CMD otherwise. lcd_db/lcd_rs/lcd_en come from the selected writer, combinationally. Inactive writer outputs are ignored.
- Counter is cleared on every state entry. No counter wrap: comparison uses the full CNT_W width.
- Mid-operation reset: everything returns to PWR_WAIT immediately, including lcd_en=0, and the full power-up/init sequence repeats.
- Cycle latency after power-up: first wr_cmd_en appears T_PWR cycles after rst_n release, ±1.

Optional Feature:
- Macro: LCD_SEQ_TIMEOUT_EN.
- Defined: a watchdog counts cycles in any *_WAIT state (INIT_WAIT/ADDR_WAIT/DATA_WAIT). At 200_000 cycles (4 ms) without the expected done, the FSM goes to PWR_WAIT, clears init_done, and pulses output timeout_err for 1 cycle.
- Not defined: no watchdog and no timeout_err port; the FSM waits for done indefinitely.

Test Plan:
- Reset release with writer models (done 100_000 cycles after en) -> first wr_cmd_en at cycle T_PWR ±1; wr_cmd sequence 0x38, 0x0C, 0x06, 0x01; init_done rises on 4th done.
- Buffer holds "HELLO WORLD     " / "FPGA LCD1602 OK " -> wr_cmd 0x80, 16 wr_data bytes matching line 1, wr_cmd 0xC0, 16 bytes matching line 2; char_addr 0..31 in order.
- After line 2's 16th done -> no en for T_REFRESH cycles, then wr_cmd=0x80; init list not repeated.
- Inject spurious wr_data_done during ADDR_WAIT and spurious wr_cmd_done during DATA_WAIT -> no state advance, no extra en pulses, byte count unchanged.
- Assert rst_n=0 mid-DATA_WAIT at col 7 -> outputs reset asynchronously; after release, a full PWR_WAIT plus the init sequence restarts.
- LCD_SEQ_TIMEOUT_EN defined, data writer model never returns done -> timeout_err pulse 200_000 cycles after wr_data_en; init_done=0; power-up sequence restarts.

Source files
------------

// File: rtl/lcd1602_seq_ctrl.sv
// HD44780 16x2 sequencer: power-up wait, init command list, then endless refresh of both lines.
// Optional watchdog on writer handshakes: define LCD_SEQ_TIMEOUT_EN (adds timeout_err port).
module lcd1602_seq_ctrl #(
`ifdef LCD_SEQ_TIMEOUT_EN
  parameter int T_TIMEOUT = 200_000,
`endif
  parameter int T_PWR     = 750_000,
  parameter int T_REFRESH = 2_500_000,
  parameter int CNT_W     = 22
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       wr_cmd_en,
  output logic [7:0] wr_cmd,
  input  logic       wr_cmd_done,
  output logic       wr_data_en,
  output logic [7:0] wr_data,
  input  logic       wr_data_done,
  input  logic [7:0] cmd_q,
  input  logic       cmd_rs,
  input  logic       cmd_en,
  input  logic [7:0] data_q,
  input  logic       data_rs,
  input  logic       data_en,
  output logic [4:0] char_addr,
  input  logic [7:0] char_data,
  output logic [7:0] lcd_db,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
`ifdef LCD_SEQ_TIMEOUT_EN
  output logic       timeout_err,
`endif
  output logic       init_done
);

  typedef enum logic [2:0] {
    PWR_WAIT, INIT_ISSUE, INIT_WAIT, ADDR_ISSUE,
    ADDR_WAIT, DATA_ISSUE, DATA_WAIT, REFRESH_WAIT
  } state_t;

  localparam logic [3:0][7:0] INIT_CMDS = {8'h01, 8'h06, 8'h0C, 8'h38};

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic             line;
  logic [3:0]       col;
  logic             sel;      // 1: data writer drives the LCD bus
  logic             bus_act;  // a writer request is outstanding

`ifdef LCD_SEQ_TIMEOUT_EN
  logic waiting, wait_done;
  always_comb begin
    waiting   = (state == INIT_WAIT) || (state == ADDR_WAIT) || (state == DATA_WAIT);
    wait_done = ((state == INIT_WAIT) || (state == ADDR_WAIT)) ? wr_cmd_done
              : (state == DATA_WAIT) ? wr_data_done : 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= PWR_WAIT;
      cnt        <= '0;
      idx        <= '0;
      line       <= 1'b0;
      col        <= '0;
      sel        <= 1'b0;
      bus_act    <= 1'b0;
      wr_cmd_en  <= 1'b0;
      wr_cmd     <= '0;
      wr_data_en <= 1'b0;
      wr_data    <= '0;
      init_done  <= 1'b0;
`ifdef LCD_SEQ_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
    end else begin
      wr_cmd_en  <= 1'b0;
      wr_data_en <= 1'b0;
`ifdef LCD_SEQ_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        PWR_WAIT:
          if (cnt == CNT_W'(T_PWR - 1)) begin
            cnt   <= '0;
            idx   <= '0;
            state <= INIT_ISSUE;
          end else cnt <= cnt + CNT_W'(1);
        INIT_ISSUE: begin
          wr_cmd_en <= 1'b1;
          wr_cmd    <= INIT_CMDS[idx];
          bus_act   <= 1'b1;
          state     <= INIT_WAIT;
        end
        INIT_WAIT:
          if (wr_cmd_done) begin
            bus_act <= 1'b0;
            cnt     <= '0;
            if (idx == 2'd3) begin
              init_done <= 1'b1;
              line      <= 1'b0;
              state     <= ADDR_ISSUE;
            end else begin
              idx   <= idx + 2'd1;
              state <= INIT_ISSUE;
            end
          end
        ADDR_ISSUE: begin
          wr_cmd_en <= 1'b1;
          wr_cmd    <= line ? 8'hC0 : 8'h80;
          bus_act   <= 1'b1;
          state     <= ADDR_WAIT;
        end
        ADDR_WAIT:
          if (wr_cmd_done) begin
            bus_act <= 1'b0;
            cnt     <= '0;
            col     <= '0;
            sel     <= 1'b1;
            state   <= DATA_ISSUE;
          end
        DATA_ISSUE: begin
          wr_data    <= char_data;
          wr_data_en <= 1'b1;
          bus_act    <= 1'b1;
          state      <= DATA_WAIT;
        end
        DATA_WAIT:
          if (wr_data_done) begin
            bus_act <= 1'b0;
            sel     <= 1'b0;
            cnt     <= '0;
            col     <= col + 4'd1;
            if (col == 4'hF) begin
              if (!line) begin
                line  <= 1'b1;
                state <= ADDR_ISSUE;
              end else state <= REFRESH_WAIT;
            end else begin
              sel   <= 1'b1;
              state <= DATA_ISSUE;
            end
          end
        REFRESH_WAIT:
          if (cnt == CNT_W'(T_REFRESH - 1)) begin
            cnt   <= '0;
            line  <= 1'b0;
            state <= ADDR_ISSUE;
          end else cnt <= cnt + CNT_W'(1);
        default: state <= PWR_WAIT;
      endcase
`ifdef LCD_SEQ_TIMEOUT_EN
      // Wait states never use the counter otherwise, so it doubles as the watchdog
      if (waiting && !wait_done) begin
        if (cnt == CNT_W'(T_TIMEOUT - 1)) begin
          state       <= PWR_WAIT;
          cnt         <= '0;
          line        <= 1'b0;
          col         <= '0;
          sel         <= 1'b0;
          bus_act     <= 1'b0;
          init_done   <= 1'b0;
          timeout_err <= 1'b1;
        end else cnt <= cnt + CNT_W'(1);
      end
`endif
    end
  end

  assign char_addr = {line, col};
  assign lcd_db    = sel ? data_q  : cmd_q;
  assign lcd_rs    = sel ? data_rs : cmd_rs;
  // Strobe only passes while a request is live, so reset or idle writers never pulse the LCD
  assign lcd_en    = bus_act & (sel ? data_en : cmd_en);
  assign lcd_rw    = 1'b0;

endmodule
